mem_port_arbiter: RTL and testbench

Clocked arbiter that shares the single memory port between the fetch requester (PC address path) and the operand requester (instruction-register address/RW path). It replaces the wired OR of addresses and RW codes in front of `memory`, so only one requester drives the port at a time. It routes read data and the completion acknowledge back to the winner. All RW codes are dual-rail, as elsewhere in the CPU: 2'b01 read, 2'b10 write, 2'b00 null/spacer, 2'b11 illegal.

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin owner of the single memory port,
// shared by the fetch and operand requesters, with watchdog and error flag.
module mem_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic [1:0]        f_rw,
    output logic              f_ack,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [1:0]        d_rw,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_rw,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [1:0] RW_NULL = 2'b00;
    localparam logic [1:0] RW_RD   = 2'b01;
    localparam logic [1:0] RW_WR   = 2'b10;
    localparam logic [1:0] RW_BAD  = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

    state_t        state, state_nxt;
    logic          owner, last;  // 1 = operand requester
    logic [CW-1:0] cnt;
    logic          f_ok, d_ok, bad, pick_d, wd_hit;
    logic          grant, done, abort, rel;
    logic [1:0]    own_rw;

    always_comb begin
        f_ok   = (f_rw == RW_RD);
        d_ok   = (d_rw == RW_RD) || (d_rw == RW_WR);
        bad    = (f_rw == RW_WR) || (f_rw == RW_BAD) || (d_rw == RW_BAD);
        pick_d = d_ok && (!f_ok || !last);
        own_rw = owner ? d_rw : f_rw;
        wd_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        rel       = 1'b0;
        unique case (state)
            IDLE: begin
                if (f_ok || d_ok) begin
                    grant     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    done      = 1'b1;
                    state_nxt = DRAIN;
                end else if (wd_hit) begin
                    abort     = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!mem_ack && own_rw == RW_NULL) begin
                    rel       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= 1'b0;
            last      <= 1'b1;
            cnt       <= '0;
            f_ack     <= 1'b0;
            d_ack     <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_rw    <= RW_NULL;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            if (grant) begin
                mem_addr  <= pick_d ? d_addr : f_addr;
                mem_rw    <= pick_d ? d_rw : f_rw;
                mem_wdata <= (pick_d && d_rw == RW_WR) ? d_wdata : '0;
                owner     <= pick_d;
                last      <= pick_d;
                cnt       <= '0;
            end
            // Saturating watchdog count while waiting on memory
            if (state == BUSY && !done && !abort && cnt != '1)
                cnt <= cnt + 1'b1;
            if (done || abort) begin
                mem_rw <= RW_NULL;
                if (owner) d_ack <= 1'b1;
                else       f_ack <= 1'b1;
            end
            if (done && mem_rw == RW_RD)
                rdata <= mem_rdata;
            if (rel) begin
                f_ack     <= 1'b0;
                d_ack     <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
            end
            if (bad || abort)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// randomized traffic against a behavioural memory/arbitration model.
module tb_mem_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk, rst_n;
    logic [AW-1:0] f_addr, d_addr, mem_addr;
    logic [1:0]    f_rw, d_rw, mem_rw;
    logic [DW-1:0] d_wdata, rdata, mem_wdata, mem_rdata;
    logic          f_ack, d_ack, mem_ack, err;

    logic [DW-1:0] mem  [256];
    logic [DW-1:0] refm [256];
    logic [DW-1:0] exp_rdata;
    int            mem_lat;
    bit            mem_dead;
    int            checks, failures;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_addr(f_addr), .f_rw(f_rw), .f_ack(f_ack),
        .d_addr(d_addr), .d_rw(d_rw), .d_wdata(d_wdata), .d_ack(d_ack),
        .rdata(rdata), .mem_addr(mem_addr), .mem_rw(mem_rw),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory device: acks mem_lat cycles after a request appears
    task automatic mem_responder();
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || mem_rw == 2'b00) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (!mem_ack && !mem_dead) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    if (mem_rw == 2'b10) mem[mem_addr] = mem_wdata;
                    else mem_rdata = mem[mem_addr];
                    mem_ack = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        f_addr = '0; f_rw = '0;
        d_addr = '0; d_rw = '0; d_wdata = '0;
        mem_dead = 1'b0;
        mem_lat = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = '0;
        @(negedge clk);
    endtask

    task automatic wait_ack(input logic want, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if ((f_ack | d_ack) == want) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({f_ack, d_ack, err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000", {f_ack, d_ack, err});
        end
        checks++;
        if (mem_rw !== 2'b00 || mem_addr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_port got rw=%b a=%h w=%h want 0",
                     mem_rw, mem_addr, mem_wdata);
        end
        checks++;
        if (rdata !== '0) begin
            failures++;
            $display("FAIL reset_rdata got=%h want=0", rdata);
        end
    endtask

    task automatic test_fetch_read();
        bit ok;
        do_reset();
        mem_lat = 2;
        mem[8'h12] = 16'hBEEF;
        refm[8'h12] = 16'hBEEF;
        f_addr = 8'h12;
        f_rw = 2'b01;
        @(negedge clk);
        checks++;
        if (mem_addr !== 8'h12 || mem_rw !== 2'b01) begin
            failures++;
            $display("FAIL fr_grant got a=%h rw=%b want 12/01", mem_addr, mem_rw);
        end
        wait_ack(1'b1, ok);
        checks++;
        if (!ok || f_ack !== 1'b1 || d_ack !== 1'b0) begin
            failures++;
            $display("FAIL fr_ack got f=%b d=%b want 1/0", f_ack, d_ack);
        end
        checks++;
        if (rdata !== 16'hBEEF || mem_rw !== 2'b00) begin
            failures++;
            $display("FAIL fr_data got rdata=%h rw=%b want beef/00", rdata, mem_rw);
        end
        exp_rdata = 16'hBEEF;
        f_rw = 2'b00;
        wait_ack(1'b0, ok);
        checks++;
        if (!ok || mem_addr !== '0) begin
            failures++;
            $display("FAIL fr_release got ack=%b a=%h want 0/0", f_ack, mem_addr);
        end
    endtask

    task automatic test_operand_write();
        bit ok;
        mem_lat = 2;
        d_addr = 8'h05;
        d_wdata = 16'h1234;
        d_rw = 2'b10;
        @(negedge clk);
        checks++;
        if (mem_rw !== 2'b10 || mem_wdata !== 16'h1234 || mem_addr !== 8'h05) begin
            failures++;
            $display("FAIL ow_grant got rw=%b w=%h a=%h want 10/1234/05",
                     mem_rw, mem_wdata, mem_addr);
        end
        wait_ack(1'b1, ok);
        checks++;
        if (!ok || d_ack !== 1'b1 || f_ack !== 1'b0 || rdata !== exp_rdata) begin
            failures++;
            $display("FAIL ow_ack got d=%b f=%b rdata=%h want 1/0/%h",
                     d_ack, f_ack, rdata, exp_rdata);
        end
        refm[8'h05] = 16'h1234;
        checks++;
        if (mem[8'h05] !== refm[8'h05]) begin
            failures++;
            $display("FAIL ow_store got=%h want=%h", mem[8'h05], refm[8'h05]);
        end
        d_rw = 2'b00;
        wait_ack(1'b0, ok);
        checks++;
        if (!ok || mem_wdata !== '0) begin
            failures++;
            $display("FAIL ow_release got ack=%b w=%h want 0/0", d_ack, mem_wdata);
        end
    endtask

    task automatic test_contention();
        bit ok, exp_d;
        do_reset();
        mem_lat = 2;
        f_addr = 8'($urandom);
        f_rw = 2'b01;
        d_addr = 8'($urandom);
        d_wdata = 16'($urandom);
        d_rw = ($urandom % 2) ? 2'b01 : 2'b10;
        for (int k = 0; k < 8; k++) begin
            exp_d = k[0];
            wait_ack(1'b1, ok);
            checks++;
            if (!ok || d_ack !== exp_d || f_ack !== !exp_d) begin
                failures++;
                $display("FAIL rr_order k=%0d got f=%b d=%b want d=%b",
                         k, f_ack, d_ack, exp_d);
            end
            if (exp_d && d_rw == 2'b10) refm[d_addr] = d_wdata;
            else exp_rdata = exp_d ? refm[d_addr] : refm[f_addr];
            checks++;
            if (rdata !== exp_rdata) begin
                failures++;
                $display("FAIL rr_data k=%0d got=%h want=%h", k, rdata, exp_rdata);
            end
            if (exp_d) d_rw = 2'b00;
            else f_rw = 2'b00;
            if (k == 7) begin
                d_rw = 2'b00;
                f_rw = 2'b00;
            end
            wait_ack(1'b0, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL rr_release k=%0d ack stuck f=%b d=%b", k, f_ack, d_ack);
            end
            if (k < 7 && exp_d) begin
                d_addr = 8'($urandom);
                d_wdata = 16'($urandom);
                d_rw = ($urandom % 2) ? 2'b01 : 2'b10;
            end else if (k < 7) begin
                f_addr = 8'($urandom);
                f_rw = 2'b01;
            end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        d_rw = 2'b11;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_rw !== 2'b00 || d_ack !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL ill_d11 got rw=%b ack=%b err=%b want 00/0/1",
                     mem_rw, d_ack, err);
        end
        do_reset();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL ill_clear got err=%b want 0", err);
        end
        f_rw = 2'b10;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_rw !== 2'b00 || f_ack !== 1'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL ill_fwr got rw=%b ack=%b err=%b want 00/0/1",
                     mem_rw, f_ack, err);
        end
    endtask

    task automatic test_watchdog();
        bit ok;
        int early;
        do_reset();
        mem_dead = 1'b1;
        f_addr = 8'($urandom);
        f_rw = 2'b01;
        @(negedge clk);
        early = 0;
        repeat (TO - 1) begin
            @(negedge clk);
            if (f_ack || err || mem_rw !== 2'b01) early++;
        end
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL wd_early got=%0d early cycles want=0", early);
        end
        @(negedge clk);
        checks++;
        if (f_ack !== 1'b1 || err !== 1'b1 || mem_rw !== 2'b00) begin
            failures++;
            $display("FAIL wd_abort got ack=%b err=%b rw=%b want 1/1/00",
                     f_ack, err, mem_rw);
        end
        f_rw = 2'b00;
        mem_dead = 1'b0;
        wait_ack(1'b0, ok);
        checks++;
        if (!ok || err !== 1'b1 || rdata !== exp_rdata) begin
            failures++;
            $display("FAIL wd_after got ack=%b err=%b rdata=%h want 0/1/%h",
                     f_ack, err, rdata, exp_rdata);
        end
    endtask

    task automatic test_reset_busy();
        bit ok;
        logic [AW-1:0] a;
        do_reset();
        mem_lat = 6;
        f_addr = 8'($urandom);
        f_rw = 2'b01;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_rw !== 2'b01) begin
            failures++;
            $display("FAIL rb_busy got rw=%b want 01", mem_rw);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({f_ack, d_ack, err, mem_rw, mem_addr, mem_wdata, rdata} !== '0) begin
            failures++;
            $display("FAIL rb_clear got ack=%b%b err=%b rw=%b a=%h w=%h r=%h",
                     f_ack, d_ack, err, mem_rw, mem_addr, mem_wdata, rdata);
        end
        f_rw = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = '0;
        mem_lat = 2;
        @(negedge clk);
        a = 8'($urandom);
        f_addr = a;
        f_rw = 2'b01;
        wait_ack(1'b1, ok);
        checks++;
        if (!ok || f_ack !== 1'b1 || rdata !== refm[a] || err !== 1'b0) begin
            failures++;
            $display("FAIL rb_fresh got ack=%b rdata=%h err=%b want 1/%h/0",
                     f_ack, rdata, err, refm[a]);
        end
        exp_rdata = refm[a];
        f_rw = 2'b00;
        wait_ack(1'b0, ok);
    endtask

    task automatic test_back_to_back();
        bit ok, is_d;
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        logic [1:0] rw;
        for (int i = 0; i < 24; i++) begin
            is_d = 1'($urandom);
            rw = (is_d && ($urandom % 2)) ? 2'b10 : 2'b01;
            a = 8'($urandom);
            w = 16'($urandom);
            mem_lat = $urandom_range(1, 4);
            if (is_d) begin
                d_addr = a; d_wdata = w; d_rw = rw;
            end else begin
                f_addr = a; f_rw = rw;
            end
            wait_ack(1'b1, ok);
            if (rw == 2'b10) refm[a] = w;
            else exp_rdata = refm[a];
            checks++;
            if (!ok || d_ack !== is_d || f_ack !== !is_d || rdata !== exp_rdata) begin
                failures++;
                $display("FAIL b2b_%0d got f=%b d=%b rdata=%h want d=%b rdata=%h",
                         i, f_ack, d_ack, rdata, is_d, exp_rdata);
            end
            f_rw = 2'b00;
            d_rw = 2'b00;
            wait_ack(1'b0, ok);
            checks++;
            if (!ok || mem_rw !== 2'b00 || mem_addr !== '0 || err !== 1'b0) begin
                failures++;
                $display("FAIL b2b_rel_%0d got rw=%b a=%h err=%b want 00/00/0",
                         i, mem_rw, mem_addr, err);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        mem_lat = 1;
        mem_dead = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            refm[i] = mem[i];
        end
        fork
            mem_responder();
        join_none
        test_reset();
        test_fetch_read();
        test_operand_write();
        test_contention();
        test_illegal();
        test_watchdog();
        test_reset_busy();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
